// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  function automatic int unsigned frame_cycles(input int unsigned clk_div,
                                               input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
    return (1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits) * clk_div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word-fall-through read, with occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (do_pop && !do_push)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO: LSB-first frames, optional parity, 1-2 stop bits.
// Defining UART_TX_BREAK_EN adds the brk input for forcing a line break.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                            brk,
`endif
  output logic                            in_ready,
  output logic                            txd,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam parity_e PMODE = parity_e'(PARITY[1:0]);

  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter combination");
  end

  tx_state_e            state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [2:0]           bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 par_bit, par_d;
  logic                 txd_d, line_d;
  logic                 tick, pop, can_start;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] pop_data;
  logic                 unused_in;

  assign unused_in = ^in_data;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (in_valid),
    .push_data(in_data[DATA_BITS-1:0]),
    .pop      (pop),
    .pop_data (pop_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || (fifo_level != '0);
  assign tick     = (cnt == CNT_W'(CLK_DIV - 1));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_cnt;
    shift_d = shift;
    par_d   = par_bit;
    pop     = 1'b0;
    if (state != IDLE) cnt_d = tick ? '0 : cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && can_start) begin
          pop     = 1'b1;
          shift_d = pop_data;
          par_d   = (^pop_data) ^ (PMODE == PAR_ODD);
          bit_d   = '0;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift >> 1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PMODE != PAR_NONE) ? PAR : STOP;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit so queued frames leave no idle gap.
            if (!fifo_empty && can_start) begin
              pop     = 1'b1;
              shift_d = pop_data;
              par_d   = (^pop_data) ^ (PMODE == PAR_ODD);
              bit_d   = '0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PAR:     txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

`ifdef UART_TX_BREAK_EN
  logic             masked;
  logic [CNT_W-1:0] guard_cnt;

  // Line stays masked until the FSM has idled a full bit period after brk drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      masked    <= 1'b0;
      guard_cnt <= '0;
    end else if (brk) begin
      masked    <= 1'b1;
      guard_cnt <= '0;
    end else if (masked && state == IDLE) begin
      if (guard_cnt == CNT_W'(CLK_DIV - 1)) begin
        masked    <= 1'b0;
        guard_cnt <= '0;
      end else begin
        guard_cnt <= guard_cnt + 1'b1;
      end
    end
  end

  assign can_start = !brk && !masked;
  assign line_d    = brk ? 1'b0 : (masked ? 1'b1 : txd_d);
`else
  assign can_start = 1'b1;
  assign line_d    = txd_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      txd     <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_d;
      shift   <= shift_d;
      par_bit <= par_d;
      txd     <= line_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three frame formats run in parallel, each
// checked against a schedule model (frame start times, occupancy) and a line monitor.
module tb_uart_tx_fifo;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         accept;
    int         start;
    logic [7:0] data;
  } item_t;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%0h expected=%0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int CD    = (g == 2) ? 5 : 4;
    localparam int DB    = (g == 1) ? 7 : 8;
    localparam int PM    = (g == 0) ? 2 : (g == 1) ? 1 : 0;
    localparam int SB    = (g == 1) ? 2 : 1;
    localparam int DEPTH = (g == 2) ? 8 : 4;
    localparam int FL    = (1 + DB + ((PM != 0) ? 1 : 0) + SB) * CD;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          rst = 1'b1;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, txd, busy;
    logic [LW-1:0] fifo_level;
`ifdef UART_TX_BREAK_EN
    logic          brk = 1'b0;
`endif

    uart_tx_fifo #(
      .CLK_DIV(CD), .DATA_BITS(DB), .PARITY(PM), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef UART_TX_BREAK_EN
      .brk(brk),
`endif
      .in_ready(in_ready), .txd(txd), .busy(busy), .fifo_level(fifo_level)
    );

    item_t exp_q[$];
    item_t outs[$];
    int    prev_end = 0;
    bit    chk_en = 1'b0;
    bit    fin = 1'b0;

    // Line level of bit slot k of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
      int ones;
      if (k == 0) return 1'b0;
      if (k <= DB) return d[k-1];
      if (PM != 0 && k == DB + 1) begin
        ones = 0;
        for (int i = 0; i < DB; i++) ones += int'(d[i]);
        return (PM == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      end
      return 1'b1;
    endfunction

    function automatic int model_level(input int n);
      int c = 0;
      foreach (outs[i]) if (outs[i].accept <= n && outs[i].start > n) c++;
      return c;
    endfunction

    function automatic bit model_busy(input int n);
      if (model_level(n) != 0) return 1'b1;
      foreach (outs[i]) if (outs[i].start <= n && n < outs[i].start + FL) return 1'b1;
      return 1'b0;
    endfunction

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send(input logic [7:0] d);
      int n;
      int waited;
      item_t it;
      in_data  = d;
      in_valid = 1'b1;
      waited   = 0;
      n        = cyc;
      while (model_level(n) >= DEPTH && waited < 20 * FL) begin
        @(negedge clk);
        waited++;
        n = cyc;
      end
      if (model_level(n) >= DEPTH) begin
        check("send_timeout", g, 1, 0);
        in_valid = 1'b0;
        return;
      end
      it.accept = n + 1;
      it.start  = (n + 2 > prev_end) ? n + 2 : prev_end;
      it.data   = d;
      prev_end  = it.start + FL;
      exp_q.push_back(it);
      outs.push_back(it);
      @(negedge clk);
      in_valid = 1'b0;
    endtask

    task automatic drain();
      while (cyc < prev_end + 2) @(negedge clk);
    endtask

    task automatic reset_pulse();
      @(negedge clk);
      #2;
      rst = 1'b0;
      exp_q.delete();
      outs.delete();
      prev_end = 0;
      #1;
      check("rst_txd", g, txd, 1);
      check("rst_level", g, fifo_level, 0);
      check("rst_ready", g, in_ready, 1);
      check("rst_busy", g, busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
    endtask

    // Occupancy, ready and busy against the schedule model, every cycle.
    initial begin : level_chk
      int n;
      int lvl;
      forever begin
        @(negedge clk);
        if (rst && chk_en) begin
          n   = cyc;
          lvl = model_level(n);
          check("fifo_level", g, fifo_level, lvl);
          check("in_ready", g, in_ready, (lvl < DEPTH) ? 1 : 0);
          check("busy", g, busy, model_busy(n) ? 1 : 0);
        end
      end
    end

    // Line monitor: a falling txd pops the next expected frame and checks it cycle by cycle.
    initial begin : mon
      item_t       cur;
      int          bad;
      bit          aborted;
      logic        e;
      logic [15:0] got_v, exp_v;
      forever begin
        @(negedge clk);
        if (!rst || !chk_en || txd !== 1'b0) continue;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_start inst=%0d t=%0t got=txd_low expected=idle_high", g, $time);
          continue;
        end
        cur = exp_q.pop_front();
        check("start_edge", g, cyc, cur.start);
        bad     = 0;
        aborted = 1'b0;
        got_v   = '0;
        exp_v   = '0;
        for (int c = 0; c < FL; c++) begin
          if (c > 0) @(negedge clk);
          if (!rst) begin
            aborted = 1'b1;
            break;
          end
          e = exp_bit(cur.data, c / CD);
          if (txd !== e) bad++;
          if (c % CD == CD / 2) begin
            got_v[c / CD] = txd;
            exp_v[c / CD] = e;
          end
        end
        if (!aborted) begin
          checks++;
          if (bad != 0) begin
            failures++;
            $display("FAIL frame inst=%0d data=%02h bad_cycles=%0d got_bits=%b expected_bits=%b",
                     g, cur.data, bad, got_v, exp_v);
          end
        end
      end
    end

    initial begin : stim
      int   s0;
      int   gap;
      int   nb;
`ifdef UART_TX_BREAK_EN
      int   low_bad;
      int   high;
`endif
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_txd", g, txd, 1);
      check("reset_busy", g, busy, 0);
      check("reset_ready", g, in_ready, 1);
      check("reset_level", g, fifo_level, 0);
      rst    = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      send(8'h68);
      drain();
      send(8'hFF);
      drain();

      // Hold valid across a burst larger than the FIFO while frame 0 is on the line.
      for (int i = 0; i < DEPTH + 2; i++) send(8'($urandom_range(0, 255)));
      drain();

      for (int it = 0; it < 20; it++) begin
        gap = $urandom_range(0, FL * 3 / 2);
        repeat (gap) @(negedge clk);
        nb = $urandom_range(1, DEPTH + 2);
        for (int i = 0; i < nb; i++) send(8'($urandom_range(0, 255)));
      end
      drain();

      send(8'hA5);
      s0 = prev_end - FL;
      send(8'($urandom_range(0, 255)));
      send(8'($urandom_range(0, 255)));
      while (cyc < s0 + 3 * CD) @(negedge clk);
      reset_pulse();
      @(negedge clk);
      send(8'h3C);
      drain();

`ifdef UART_TX_BREAK_EN
      chk_en = 1'b0;
      send(8'h68);
      s0 = prev_end - FL;
      send(8'h55);
      while (cyc < s0 + 8) @(negedge clk);
      brk     = 1'b1;
      low_bad = 0;
      repeat (100) begin
        @(negedge clk);
        if (txd !== 1'b0) low_bad++;
      end
      brk  = 1'b0;
      high = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (txd !== 1'b1) break;
        high++;
      end
      check("brk_low_cycles_bad", g, low_bad, 0);
      check("brk_guard_ok", g, (high >= CD) ? 1 : 0, 1);
      check("brk_restart_low", g, txd, 0);
      repeat (FL + 4) @(negedge clk);
      reset_pulse();
      chk_en = 1'b1;
      @(negedge clk);
      send(8'h96);
      drain();
`endif

      repeat (2) @(negedge clk);
      check("scoreboard_empty", g, exp_q.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin : main
    int waited;
    waited = 0;
    while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && waited < 60000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin)) begin
      failures++;
      $display("FAIL run_timeout got=unfinished expected=all_instances_done");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
